// File: rtl/bist_adder_ctrl.sv
// -----------------------------------------------------------------------------
// bist_adder_ctrl
//
// Built-in self-test sequencer for the 16-bit adder BIST top.
//   - A 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1) drives operands and carry-in.
//   - A 17-bit MISR (x^17+x^14+1) compacts every {cout, sum} from the adder.
//   - When the run ends, the final signature is compared against GOLDEN.
//
// Flow: IDLE --start--> SEED --> RUN (PATTERNS cycles) --> DONE --start--> SEED
//
// The adder sits combinationally between tpg_* and dut_sum. The pattern held
// in the LFSR during a RUN cycle is compacted at the edge that ends that cycle.
// -----------------------------------------------------------------------------
module bist_adder_ctrl #(
   parameter int unsigned PATTERNS  = 64,             // 1..65535
   parameter logic [31:0] LFSR_SEED = 32'h0000_0001,  // zero is replaced by 1
   parameter logic [16:0] MISR_SEED = 17'h0_0000,
   parameter logic [16:0] GOLDEN    = 17'h0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [15:0] tpg_a,
   output logic [15:0] tpg_b,
   output logic        tpg_cin,
   input  logic [16:0] dut_sum,
   output logic [16:0] signature,
   output logic        busy,
   output logic        finish,
   output logic        pass
);

   // An all-zero LFSR would lock up, so a zero seed falls back to 1.
   localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'd0) ? 32'h0000_0001
                                                           : LFSR_SEED;

   // Count value seen in the final RUN cycle.
   localparam logic [15:0] CNT_LAST = 16'(PATTERNS - 1);

   // FSM encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEED = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [31:0] lfsr;
   logic [31:0] lfsr_next;
   logic [16:0] misr;
   logic [16:0] misr_next;
   logic [15:0] cnt;
   logic        last_pattern;
   logic        enter_done;

   assign last_pattern = (cnt == CNT_LAST);
   assign enter_done   = (state == RUN) && last_pattern;

   // Next-state logic for the IDLE/SEED/RUN/DONE sequencer.
   always_comb begin
      // NOTE: state_next gets a default before the case so that every path
      // assigns it; a missing assignment would otherwise infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SEED;
         SEED:    state_next = RUN;
         RUN:     if (last_pattern) state_next = DONE;
         DONE:    if (start) state_next = SEED;
         default: state_next = IDLE;
      endcase
   end

   // Pattern generator step and signature compaction step.
   always_comb begin
      lfsr_next       = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      misr_next[0]    = misr[16] ^ misr[13] ^ dut_sum[0];
      misr_next[16:1] = misr[15:0] ^ dut_sum[16:1];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // LFSR, MISR and pattern counter: load in SEED, advance in RUN, hold elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED_EFF;
         misr <= '0;
         cnt  <= '0;
      end else begin
         case (state)
            SEED: begin
               lfsr <= SEED_EFF;
               misr <= MISR_SEED;
               cnt  <= '0;
            end
            RUN: begin
               lfsr <= lfsr_next;
               misr <= misr_next;
               cnt  <= cnt + 16'd1;
            end
            default: begin
               lfsr <= lfsr;
               misr <= misr;
               cnt  <= cnt;
            end
         endcase
      end
   end

   // Registered status flags decoded from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         finish <= 1'b0;
      end else begin
         busy   <= (state_next == SEED) || (state_next == RUN);
         finish <= (state_next == DONE);
      end
   end

   // Pass verdict: captured from the final compaction on entry to DONE,
   // held through DONE, cleared when a new run starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass <= 1'b0;
      end else if (enter_done) begin
         pass <= (misr_next == GOLDEN);
      end else if (state_next != DONE) begin
         pass <= 1'b0;
      end
   end

   assign tpg_a     = lfsr[31:16];
   assign tpg_b     = lfsr[15:0];
   assign tpg_cin   = lfsr[31] ^ lfsr[0];
   assign signature = misr;

endmodule

// File: tb/tb_bist_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bist_adder_ctrl
//
// Two controller instances share clock and reset:
//   u_p2  : PATTERNS = 2, GOLDEN = 0 -- first-pattern walk-through.
//   u_p64 : PATTERNS = 64, GOLDEN from the reference model -- full runs,
//           fault injection, restart, back-to-back and reset mid-run.
// Each instance is closed around an ideal adder. Expected results for every
// 64-pattern run are queued when start is driven and popped when finish rises.
// -----------------------------------------------------------------------------
module tb_bist_adder_ctrl;

   // Reference signature: LFSR as a masked parity shift, MISR as shift-with-
   // feedback then XOR of the sum. fault_at flips sum[0] in that RUN cycle.
   function automatic logic [16:0] ref_sig(input int n, input int fault_at);
      logic [31:0] r;
      logic [16:0] m;
      logic [16:0] s;
      logic        fb;
      r = 32'h0000_0001;
      m = 17'h0;
      for (int k = 1; k <= n; k++) begin
         s = {1'b0, r[31:16]} + {1'b0, r[15:0]} + {16'b0, r[31] ^ r[0]};
         if (k == fault_at) s[0] = ~s[0];
         fb = m[16] ^ m[13];
         m  = {m[15:0], fb} ^ s;
         r  = {r[30:0], ^(r & 32'h8020_0003)};
      end
      return m;
   endfunction

   localparam logic [16:0] GOLD64    = ref_sig(64, 0);
   localparam logic [16:0] FAULT_SIG = ref_sig(64, 10);

   typedef struct packed {
      logic [16:0] sig;
      logic        pass;
      logic [31:0] at;     // finish edge, counted from the first start edge
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic clk = 1'b0;
   logic rst_n;
   logic start2;
   logic start64;
   logic inject;

   logic [15:0] a2, b2, a64, b64;
   logic        cin2, cin64;
   logic [16:0] sum2, sum64, sig2, sig64;
   logic        busy2, finish2, pass2;
   logic        busy64, finish64, pass64;

   always #5 clk = ~clk;

   // Ideal adders; the 64-pattern one can flip bit 0 on demand.
   assign sum2  = {1'b0, a2} + {1'b0, b2} + {16'b0, cin2};
   assign sum64 = ({1'b0, a64} + {1'b0, b64} + {16'b0, cin64}) ^ {16'b0, inject};

   bist_adder_ctrl #(
      .PATTERNS  (2),
      .LFSR_SEED (32'h0000_0001),
      .MISR_SEED (17'h0_0000),
      .GOLDEN    (17'h0_0000)
   ) u_p2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .tpg_a     (a2),
      .tpg_b     (b2),
      .tpg_cin   (cin2),
      .dut_sum   (sum2),
      .signature (sig2),
      .busy      (busy2),
      .finish    (finish2),
      .pass      (pass2)
   );

   bist_adder_ctrl #(
      .PATTERNS  (64),
      .LFSR_SEED (32'h0000_0000),   // exercises the zero-seed fallback
      .MISR_SEED (17'h0_0000),
      .GOLDEN    (GOLD64)
   ) u_p64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start64),
      .tpg_a     (a64),
      .tpg_b     (b64),
      .tpg_cin   (cin64),
      .dut_sum   (sum64),
      .signature (sig64),
      .busy      (busy64),
      .finish    (finish64),
      .pass      (pass64)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle64(input string tag);
      check({tag, "_sig"},    32'(sig64),    32'h0);
      check({tag, "_busy"},   32'(busy64),   32'h0);
      check({tag, "_finish"}, 32'(finish64), 32'h0);
      check({tag, "_pass"},   32'(pass64),   32'h0);
      check({tag, "_a"},      32'(a64),      32'h0000);
      check({tag, "_b"},      32'(b64),      32'h0001);
      check({tag, "_cin"},    32'(cin64),    32'h1);
   endtask

   // Drive start for nruns back-to-back 64-pattern runs, then follow the DUT
   // until every queued expectation has been matched against a finish rise.
   task automatic run64(input int nruns, input bit fault, input string tag);
      exp_t        e;
      int          k;
      int          last_at;
      int          both;
      int          fin_seen;
      logic        prev_fin;
      logic [16:0] last_sig;
      for (int r = 0; r < nruns; r++) begin
         e.sig  = fault ? FAULT_SIG : GOLD64;
         e.pass = !fault;
         e.at   = 32'(65 + r * 66);
         exp_q.push_back(e);
      end
      last_at  = 65 + (nruns - 1) * 66;
      last_sig = fault ? FAULT_SIG : GOLD64;
      start64  = 1'b1;
      tick();                          // start edge: enters SEED
      k       = 0;
      start64 = (nruns > 1);
      check({tag, "_busy_seed"},   32'(busy64),   32'h1);
      check({tag, "_finish_drop"}, 32'(finish64), 32'h0);
      prev_fin = 1'b0;
      both     = 0;
      fin_seen = 0;
      while (exp_q.size() != 0 && k <= last_at + 20) begin
         tick();
         k++;
         inject  = fault && (k == 10);
         start64 = (k < (nruns - 1) * 66);
         if (busy64 && finish64) both++;
         if (finish64) fin_seen++;
         if (finish64 && !prev_fin) begin
            e = exp_q.pop_front();
            check({tag, "_finish_at"}, 32'(k),      e.at);
            check({tag, "_sig"},       32'(sig64),  32'(e.sig));
            check({tag, "_pass"},      32'(pass64), 32'(e.pass));
            check({tag, "_busy_low"},  32'(busy64), 32'h0);
         end
         prev_fin = finish64;
      end
      inject  = 1'b0;
      start64 = 1'b0;
      check({tag, "_timeout_left"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      check({tag, "_done_cycles"}, 32'(fin_seen), 32'(nruns));
      check({tag, "_busy_and_finish"}, 32'(both), 32'h0);
      tick();                          // DONE holds with start low
      check({tag, "_hold_finish"}, 32'(finish64), 32'h1);
      check({tag, "_hold_sig"},    32'(sig64),    32'(last_sig));
   endtask

   initial begin
      rst_n   = 1'b0;
      start2  = 1'b0;
      start64 = 1'b0;
      inject  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;

      // Reset state, then confirm nothing moves without start.
      check_idle64("reset");
      check("reset_p2_sig", 32'(sig2), 32'h0);
      repeat (5) tick();
      check_idle64("idle_stable");

      // Two-pattern walk-through on u_p2.
      start2 = 1'b1;
      tick();                          // edge t
      start2 = 1'b0;
      check("p2_busy_seed", 32'(busy2), 32'h1);
      tick();                          // edge t+1: RUN cycle 1
      check("p2_c1_a",   32'(a2),   32'h0000);
      check("p2_c1_b",   32'(b2),   32'h0001);
      check("p2_c1_cin", 32'(cin2), 32'h1);
      tick();                          // edge t+2: RUN cycle 2
      check("p2_c1_sig",    32'(sig2),    32'h00002);
      check("p2_c2_a",      32'(a2),      32'h0000);
      check("p2_c2_b",      32'(b2),      32'h0003);
      check("p2_c2_cin",    32'(cin2),    32'h1);
      check("p2_c2_finish", 32'(finish2), 32'h0);
      check("p2_c2_busy",   32'(busy2),   32'h1);
      tick();                          // edge t+3
      check("p2_c2_sig",  32'(sig2),    32'h00000);
      check("p2_finish",  32'(finish2), 32'h1);
      check("p2_pass",    32'(pass2),   32'h1);
      check("p2_busy",    32'(busy2),   32'h0);

      // Full runs, restart from DONE, fault injection, back-to-back.
      run64(1, 1'b0, "full");
      run64(1, 1'b0, "restart");
      run64(1, 1'b1, "fault");
      run64(1, 1'b0, "after_fault");
      run64(2, 1'b0, "b2b");

      // Reset in RUN cycle 20, then a clean run.
      start64 = 1'b1;
      tick();
      start64 = 1'b0;
      repeat (20) tick();
      check("mid_busy_before", 32'(busy64), 32'h1);
      rst_n = 1'b0;
      #1;
      check_idle64("mid_reset");
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_idle64("post_reset");
      run64(1, 1'b0, "post_reset_run");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so a stuck run cannot hang the bench.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
               n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
